// File: rtl/tug_referee.sv
// Tug-of-war referee: tracks the rope position driven by two players' press
// pulses, declares round winners at the rope ends, keeps saturating scores and
// ends the match once a player reaches SCORE_MAX round wins.
module tug_referee #(
  parameter int HALF      = 4,
  parameter int SCORE_MAX = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            left_press,
  input  logic            right_press,
  input  logic            restart,
  output logic [3:0]      pos,
  output logic [2*HALF:0] leds,
  output logic            round_over,
  output logic            winner,
  output logic [2:0]      left_score,
  output logic [2:0]      right_score,
  output logic            match_over,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    ROUND_WON  = 2'd1,
    MATCH_DONE = 2'd2
  } state_t;

  localparam logic [3:0] POS_CENTER = 4'(HALF);
  localparam logic [3:0] POS_RIGHT  = 4'(2 * HALF);
  localparam logic [2:0] SCORE_TOP  = 3'(SCORE_MAX);

  state_t      state_q, state_d;
  logic [3:0]  pos_q, pos_d;
  logic        round_over_q, round_over_d;
  logic        winner_q, winner_d;
  logic [2:0]  left_score_q, left_score_d;
  logic [2:0]  right_score_q, right_score_d;
  logic        match_over_q, match_over_d;
  logic [2:0]  left_inc, right_inc;

  // Register all state; active-low synchronous reset returns to a fresh match.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= PLAY;
      pos_q         <= POS_CENTER;
      round_over_q  <= 1'b0;
      winner_q      <= 1'b0;
      left_score_q  <= 3'd0;
      right_score_q <= 3'd0;
      match_over_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      round_over_q  <= round_over_d;
      winner_q      <= winner_d;
      left_score_q  <= left_score_d;
      right_score_q <= right_score_d;
      match_over_q  <= match_over_d;
    end
  end

  // Next-state logic: rope movement in PLAY, round/match wins at the ends,
  // restart handling while a winner is held (presses ignored there).
  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    round_over_d  = round_over_q;
    winner_d      = winner_q;
    left_score_d  = left_score_q;
    right_score_d = right_score_q;
    match_over_d  = match_over_q;
    // Saturating increments; a score already at the top never wraps.
    left_inc  = (left_score_q == SCORE_TOP) ? left_score_q : left_score_q + 3'd1;
    right_inc = (right_score_q == SCORE_TOP) ? right_score_q : right_score_q + 3'd1;

    unique case (state_q)
      PLAY: begin
        // Simultaneous presses cancel, so only a lone press acts.
        if (left_press && !right_press) begin
          if (pos_q != 4'd0) begin
            pos_d = pos_q - 4'd1;
          end else begin
            winner_d     = 1'b0;
            round_over_d = 1'b1;
            left_score_d = left_inc;
            if (left_inc == SCORE_TOP) begin
              state_d      = MATCH_DONE;
              match_over_d = 1'b1;
            end else begin
              state_d = ROUND_WON;
            end
          end
        end else if (right_press && !left_press) begin
          if (pos_q != POS_RIGHT) begin
            pos_d = pos_q + 4'd1;
          end else begin
            winner_d      = 1'b1;
            round_over_d  = 1'b1;
            right_score_d = right_inc;
            if (right_inc == SCORE_TOP) begin
              state_d      = MATCH_DONE;
              match_over_d = 1'b1;
            end else begin
              state_d = ROUND_WON;
            end
          end
        end
      end
      ROUND_WON: begin
        if (restart) begin
          state_d      = PLAY;
          pos_d        = POS_CENTER;
          round_over_d = 1'b0;
        end
      end
      MATCH_DONE: begin
        if (restart) begin
          state_d       = PLAY;
          pos_d         = POS_CENTER;
          round_over_d  = 1'b0;
          left_score_d  = 3'd0;
          right_score_d = 3'd0;
          match_over_d  = 1'b0;
        end
      end
      default: begin
        state_d = PLAY;
      end
    endcase
  end

  // One-hot LED decode of the rope position.
  always_comb begin
    leds = '0;
    for (int i = 0; i <= 2 * HALF; i++) begin
      leds[i] = (pos_q == 4'(i));
    end
  end

  assign pos         = pos_q;
  assign round_over  = round_over_q;
  assign winner      = winner_q;
  assign left_score  = left_score_q;
  assign right_score = right_score_q;
  assign match_over  = match_over_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_tug_referee.sv
// Bench for tug_referee: directed scenarios followed by biased random play,
// every cycle compared against a rule-level model of the game.
module tb_tug_referee;

  localparam int HALF      = 4;
  localparam int SCORE_MAX = 7;

  logic            clk;
  logic            reset;
  logic            left_press, right_press, restart;
  logic [3:0]      pos;
  logic [2*HALF:0] leds;
  logic            round_over, winner, match_over;
  logic [2:0]      left_score, right_score;
  logic [1:0]      state_dbg;

  int n_vec;
  int n_err;

  // Game model: rope position, scores, and whether a round/match is held.
  int m_pos;
  int m_ls, m_rs;
  bit m_round, m_match, m_win;

  tug_referee #(.HALF(HALF), .SCORE_MAX(SCORE_MAX)) dut (
    .clk(clk), .reset(reset),
    .left_press(left_press), .right_press(right_press), .restart(restart),
    .pos(pos), .leds(leds), .round_over(round_over), .winner(winner),
    .left_score(left_score), .right_score(right_score),
    .match_over(match_over), .state_dbg(state_dbg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Apply the game rules for one clock edge.
  task automatic model_step(input bit l, input bit r, input bit rs, input bit rst_n);
    if (!rst_n) begin
      m_pos = HALF; m_ls = 0; m_rs = 0;
      m_round = 0; m_match = 0; m_win = 0;
    end else if (!m_round) begin
      if (l && !r) begin
        if (m_pos > 0) m_pos = m_pos - 1;
        else begin
          m_win = 0; m_round = 1;
          if (m_ls < SCORE_MAX) m_ls = m_ls + 1;
          m_match = (m_ls == SCORE_MAX);
        end
      end else if (r && !l) begin
        if (m_pos < 2 * HALF) m_pos = m_pos + 1;
        else begin
          m_win = 1; m_round = 1;
          if (m_rs < SCORE_MAX) m_rs = m_rs + 1;
          m_match = (m_rs == SCORE_MAX);
        end
      end
    end else if (rs) begin
      m_pos = HALF; m_round = 0;
      if (m_match) begin
        m_ls = 0; m_rs = 0; m_match = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_leds;
    exp_leds = 32'd1 << m_pos;
    check("pos", 32'(pos), 32'(m_pos));
    check("leds", 32'(leds), exp_leds);
    check("round_over", 32'(round_over), 32'(m_round));
    if (m_round) check("winner", 32'(winner), 32'(m_win));
    check("left_score", 32'(left_score), 32'(m_ls));
    check("right_score", 32'(right_score), 32'(m_rs));
    check("match_over", 32'(match_over), 32'(m_match));
  endtask

  // Driver: one clock cycle with the given inputs, then model update and compare.
  task automatic cyc(input bit l, input bit r, input bit rs, input bit rst_n);
    @(negedge clk);
    left_press = l; right_press = r; restart = rs; reset = rst_n;
    @(posedge clk);
    model_step(l, r, rs, rst_n);
    #1;
    compare_all();
  endtask

  task automatic left_wins_round();
    repeat (HALF + 1) cyc(1, 0, 0, 1);
    cyc(0, 0, 1, 1);
  endtask

  task automatic right_wins_round();
    repeat (HALF + 1) cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    left_press = 0; right_press = 0; restart = 0; reset = 0;
    m_pos = HALF; m_ls = 0; m_rs = 0; m_round = 0; m_match = 0; m_win = 0;

    // Reset state.
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("reset_pos", 32'(pos), 32'd4);
    check("reset_leds", 32'(leds), 32'h10);

    // Four left presses three cycles apart walk the rope to 0.
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 1);
      check("walk_pos", 32'(pos), 32'(3 - k));
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
    end
    // One more left press wins the round; further presses are ignored.
    cyc(1, 0, 0, 1);
    check("win_round_over", 32'(round_over), 32'd1);
    check("win_winner", 32'(winner), 32'd0);
    check("win_left_score", 32'(left_score), 32'd1);
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1);
    check("held_pos", 32'(pos), 32'd0);

    // Restart together with a press: press discarded, score kept.
    cyc(0, 1, 1, 1);
    check("rs_press_pos", 32'(pos), 32'd4);
    check("rs_press_score", 32'(left_score), 32'd1);
    check("rs_press_round", 32'(round_over), 32'd0);
    // First PLAY cycle press is honoured; simultaneous presses cancel.
    cyc(1, 1, 0, 1);
    check("cancel_pos", 32'(pos), 32'd4);
    cyc(0, 1, 0, 1);
    check("right_step_pos", 32'(pos), 32'd5);
    cyc(1, 0, 0, 1);

    // Bring left to 6 wins, then the 7th ends the match.
    repeat (5) left_wins_round();
    check("left_six", 32'(left_score), 32'd6);
    repeat (HALF + 1) cyc(1, 0, 0, 1);
    check("match_left_score", 32'(left_score), 32'd7);
    check("match_over", 32'(match_over), 32'd1);
    cyc(1, 0, 0, 1);
    check("match_sat", 32'(left_score), 32'd7);
    cyc(0, 0, 1, 1);
    check("newmatch_pos", 32'(pos), 32'd4);
    check("newmatch_ls", 32'(left_score), 32'd0);
    check("newmatch_mo", 32'(match_over), 32'd0);
    // Restart during PLAY is ignored.
    cyc(0, 1, 1, 1);
    check("play_restart_pos", 32'(pos), 32'd5);
    cyc(1, 0, 0, 1);

    // Right reaches 2 wins and pos 6, then a reset discards everything.
    repeat (2) right_wins_round();
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    check("pre_reset_pos", 32'(pos), 32'd6);
    check("pre_reset_rs", 32'(right_score), 32'd2);
    cyc(1, 0, 1, 0);
    check("mid_reset_pos", 32'(pos), 32'd4);
    check("mid_reset_rs", 32'(right_score), 32'd0);

    // Biased random play, with occasional restarts and resets.
    begin
      int pl, pr;
      pl = 50; pr = 50;
      for (int c = 0; c < 6000; c++) begin
        bit l, r, rs, rn;
        if (c % 150 == 0) begin
          pl = $urandom_range(5, 80);
          pr = $urandom_range(5, 80);
        end
        l  = ($urandom_range(0, 99) < pl);
        r  = ($urandom_range(0, 99) < pr);
        rs = ($urandom_range(0, 99) < 12);
        rn = ($urandom_range(0, 999) >= 3);
        cyc(l, r, rs, rn);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tug_referee.md
TUG_REFEREE -- requirements
Module: tug_referee

Interface
REQ-001 Parameter HALF, default 4, rope positions on each side of center; position range 0..2*HALF, center = HALF.
REQ-002 Parameter SCORE_MAX, default 7, round wins needed to end the match; score width 3 bits.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  synchronous, active-low reset; sampled on posedge clk, asserted when 0.
REQ-005 Port left_press  input  1  one-cycle press pulse from the left player's edge detector.
REQ-006 Port right_press  input  1  one-cycle press pulse from the right player's edge detector.
REQ-007 Port restart  input  1  one-cycle pulse requesting the next round, or a new match when the match is over.
REQ-008 Port pos  output  4  current rope position, 0 = left edge, 2*HALF = right edge.
REQ-009 Port leds  output  2*HALF+1  one-hot decode of pos; bit pos = 1, all other bits 0.
REQ-010 Port round_over  output  1  high while a round winner is held.
REQ-011 Port winner  output  1  0 = left, 1 = right; meaningful only while round_over = 1.
REQ-012 Port left_score, right_score  output  3 each  round wins per player.
REQ-013 Port match_over  output  1  high once either score equals SCORE_MAX.

Function
REQ-014 FSM states: PLAY, ROUND_WON and MATCH_DONE; all outputs except leds are registered.
REQ-015 PLAY, left_press only, pos > 0: pos <= pos-1 on the next edge.
REQ-016 PLAY, right_press only, pos < 2*HALF: pos <= pos+1 on the next edge.
REQ-017 PLAY, left_press and right_press in the same cycle: the presses cancel; pos, scores and state are unchanged.
REQ-018 PLAY, left_press only, pos == 0: next edge enters ROUND_WON with winner = 0, left_score +1 and pos held at 0.
REQ-019 PLAY, right_press only, pos == 2*HALF: next edge enters ROUND_WON with winner = 1, right_score +1 and pos held at 2*HALF.
REQ-020 Winning-press latency: round_over rises and the score updates exactly 1 cycle after the winning press cycle.
REQ-021 A win that makes the winner's score equal SCORE_MAX enters MATCH_DONE instead of ROUND_WON.
- round_over = 1, match_over = 1, winner set.
REQ-022 Scores never exceed SCORE_MAX; any increment at SCORE_MAX is suppressed (saturating).
REQ-023 ROUND_WON and MATCH_DONE: left_press and right_press are ignored.
REQ-024 ROUND_WON, restart: next edge enters PLAY.
- pos <= HALF, round_over <= 0; scores kept.
REQ-025 MATCH_DONE, restart: next edge enters PLAY.
- pos <= HALF, both scores <= 0, round_over <= 0, match_over <= 0.
REQ-026 PLAY, restart: ignored.
REQ-027 restart coinciding with a press in ROUND_WON or MATCH_DONE: restart takes effect and the press is discarded.
REQ-028 A press arriving in the first PLAY cycle after restart is honoured normally.

Reset
REQ-029 reset == 0 at a clock edge forces, on that edge:
- state = PLAY, pos = HALF, leds = one-hot at HALF;
- round_over = 0, winner = 0, left_score = 0, right_score = 0, match_over = 0.
REQ-030 Reset has priority over press and restart inputs in the same cycle.
REQ-031 Reset mid-round or mid-match discards all progress.

Verification
REQ-032 Reset, then 4 left_press pulses 3 cycles apart -> pos steps 4,3,2,1,0, each step 1 cycle after its pulse, leds one-hot tracks pos.
REQ-033 pos = 0 in PLAY, one more left_press -> round_over = 1, winner = 0, left_score = 1 the next cycle; further presses leave pos = 0.
REQ-034 pos = 4, left_press and right_press in the same cycle -> pos stays 4, no score change; right_press alone next -> pos = 5.
REQ-035 left_score = 6 with SCORE_MAX = 7, left wins a round -> left_score = 7 and match_over = 1; restart -> pos = 4, both scores 0, match_over = 0.
REQ-036 ROUND_WON, restart together with right_press -> PLAY with pos = 4 and score kept; the press has no effect.
REQ-037 pos = 6 with right_score = 2, reset = 0 for one cycle -> all outputs at reset values on that edge, pos = 4.
